spi_frame_sequencer: RTL and testbench
======================================

# spi_frame_sequencer

Parametrised frame sequencer between the vibration DSP output and `SPI_Master_With_Single_CS`. It accepts one multi-channel sample word per frame over a valid/ready handshake and serialises it MSB-first, channel 0 first, as single-cycle byte strobes. Each frame is padded to a fixed DMA-aligned length, followed by a programmable inter-frame gap. A burst stops after a fixed number of frames. It replaces the fixed 6-byte/1-axis test sender with an N-channel, burst-counted streamer.

## Interface
Parameters:
- `NUM_CH`, 3: channels (axes) per frame, ≥1.
- `SAMPLE_BYTES`, 6: bytes per channel sample, ≥1.
- `FRAME_BYTES`, 24: bytes per SPI transaction. Must satisfy FRAME_BYTES ≥ NUM_CH·SAMPLE_BYTES and FRAME_BYTES ≤ the master's MAX_BYTES_PER_CS.
- `PAD_BYTE`, 8'hAB: fill value for bytes beyond the payload.
- `DELAY_CYCLES`, 2_000_000: idle clocks between frames (20 ms at 100 MHz), ≥1.
- `FRAMES_PER_BURST`, 1024: frames sent per `start`, ≥1.

Ports:
- `CLK100MHZ` in 1: system clock.
- `RESET_N` in 1: one clock; reset is asynchronous and active-low.
- `start` in 1: pulse that begins a burst; ignored while `busy`.
- `sample_data` in NUM_CH·SAMPLE_BYTES·8: payload. Bits [W-1-8k -: 8] are frame byte k.
- `sample_valid` in 1 / `sample_ready` out 1: sample handshake.
- `tx_byte` out 8: byte to the master's `i_TX_Byte`.
- `tx_dv` out 1: byte strobe to the master's `i_TX_DV`.
- `tx_ready` in 1: from the master's `o_TX_Ready`.
- `tx_count` out $clog2(MAX_BYTES_PER_CS+1): constant FRAME_BYTES, sized to the master's `i_TX_Count` port.
- `busy` out 1: high in any state other than S_IDLE.
- `frame_count` out $clog2(FRAMES_PER_BURST+1): frames completed in the current burst.
- `burst_done` out 1: 1-cycle pulse at burst end.

## Operation
- Reset values:
  - state = S_IDLE.
  - `tx_dv`, `sample_ready`, `busy`, `burst_done` = 0.
  - `tx_byte` = 0.
  - `frame_count` = 0.
  - byte index = 0, delay counter = 0, sample buffer = 0.
- All outputs except `tx_count` are registered.
- States and transitions:
  - S_IDLE: on `start` → S_WAIT_SAMPLE, clear `frame_count`.
  - S_WAIT_SAMPLE: `sample_ready`=1. On `sample_valid`, latch `sample_data` into the buffer, index←0 → S_SEND. Input is not sampled again until the next S_WAIT_SAMPLE.
  - S_SEND: waits for `tx_ready`=1. Then register `tx_dv`=1 and `tx_byte` = buffer byte[index] if index < NUM_CH·SAMPLE_BYTES, else PAD_BYTE → S_HOLD.
  - S_HOLD: `tx_dv` is visible this cycle only. `tx_ready` is ignored, because the master deasserts it one cycle late. If index = FRAME_BYTES-1 → S_DRAIN; else index+1 → S_SEND.
  - S_DRAIN: wait for `tx_ready`=1 (CS has returned high) → S_DELAY, counter←0.
  - S_DELAY: count to DELAY_CYCLES-1. Then `frame_count`+1; if the new value equals FRAMES_PER_BURST → S_DONE, else → S_WAIT_SAMPLE.
  - S_DONE: `burst_done`=1 for one cycle → S_IDLE. `frame_count` holds its final value until the next `start`.
- The buffer holds a sample stable for the whole frame, so upstream may change `sample_data` after the handshake.
- `start` asserted while `busy` has no effect. `start` and S_DONE in the same cycle: the start is ignored.
- `RESET_N` asserted mid-frame: `tx_dv` drops immediately and all state returns to reset values. The master is reset by the same net.

## Timing
- `start` seen at edge 0 → `sample_ready`=1 from cycle 1.
- Handshake at edge N with `tx_ready`=1 → `tx_dv` high during cycle N+2 (S_SEND registers at edge N+1).
- Minimum spacing between `tx_dv` pulses is 2 cycles; actual spacing is paced by `tx_ready` (about 34 cycles per byte at 25 MHz SCLK).
- Exactly FRAME_BYTES `tx_dv` pulses per frame, never two in consecutive cycles.
- Gap from the post-frame `tx_ready` rise to the next `sample_ready` is DELAY_CYCLES+1 cycles.
- `frame_count` increments on the last S_DELAY edge. It never exceeds FRAMES_PER_BURST and does not wrap.

## Test plan
Bench configuration: NUM_CH=2, SAMPLE_BYTES=3, FRAME_BYTES=8, DELAY_CYCLES=10, FRAMES_PER_BURST=3, with a behavioural master model that drops `tx_ready` one cycle after `tx_dv` and holds it low for 32 cycles.
- Single frame: sample 48'hF1020304056F → byte stream F1,02,03,04,05,6F,AB,AB; exactly 8 `tx_dv` pulses; `tx_count`=8.
- Full burst of 3 frames with distinct samples → `frame_count` steps 1,2,3; one `burst_done` pulse; return to S_IDLE; `sample_ready` low after the burst.
- `sample_valid` held low for 50 cycles in S_WAIT_SAMPLE → no `tx_dv`; `sample_data` changed mid-frame → transmitted bytes unchanged.
- `start` pulsed during frame 2 → ignored; burst still ends after exactly 3 frames.
- `RESET_N` low during byte 4 → `tx_dv`=0, `busy`=0, `frame_count`=0 in the same cycle; a new `start` after release sends a full 8-byte frame.
- Inter-frame gap: measured from the post-frame `tx_ready` rise to `sample_ready`=1 → exactly 11 cycles.

Source files
------------

// File: rtl/spi_frame_sequencer.sv
// Frame sequencer feeding SPI_Master_With_Single_CS: latches one multi-channel
// sample per frame, emits it MSB-first as byte strobes, pads, then waits out a gap.
//
// state         | meaning
// --------------+-------------------------------------------------------------
// S_IDLE        | no burst active, waiting for start
// S_WAIT_SAMPLE | sample_ready high, waiting for sample_valid
// S_SEND        | waiting for master ready, then strobe next byte
// S_HOLD        | tx_dv visible; master's ready is stale, so it is ignored
// S_DRAIN       | last byte issued, waiting for master to finish (CS high)
// S_DELAY       | inter-frame gap, frame_count bumped on the final cycle
// S_DONE        | burst_done pulse, then back to idle
module spi_frame_sequencer #(
   parameter int          NUM_CH           = 3,
   parameter int          SAMPLE_BYTES     = 6,
   parameter int          FRAME_BYTES      = 24,
   parameter logic [7:0]  PAD_BYTE         = 8'hAB,
   parameter int          DELAY_CYCLES     = 2_000_000,
   parameter int          FRAMES_PER_BURST = 1024,
   parameter int          MAX_BYTES_PER_CS = 32,
   localparam int         SAMPLE_W         = NUM_CH * SAMPLE_BYTES * 8,
   localparam int         TC_W             = $clog2(MAX_BYTES_PER_CS + 1),
   localparam int         FC_W             = $clog2(FRAMES_PER_BURST + 1)
) (
   input  logic                CLK100MHZ,
   input  logic                RESET_N,
   input  logic                start,
   input  logic [SAMPLE_W-1:0] sample_data,
   input  logic                sample_valid,
   output logic                sample_ready,
   output logic [7:0]          tx_byte,
   output logic                tx_dv,
   input  logic                tx_ready,
   output logic [TC_W-1:0]     tx_count,
   output logic                busy,
   output logic [FC_W-1:0]     frame_count,
   output logic                burst_done
);

   localparam int PAYLOAD_BYTES = NUM_CH * SAMPLE_BYTES;
   localparam int IDX_W         = $clog2(FRAME_BYTES + 1);
   localparam int DLY_W         = $clog2(DELAY_CYCLES + 1);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BYTES - 1);
   localparam logic [IDX_W-1:0] IDX_PAY  = IDX_W'(PAYLOAD_BYTES);
   localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DELAY_CYCLES - 1);
   localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FRAMES_PER_BURST);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_SAMPLE,
      S_SEND,
      S_HOLD,
      S_DRAIN,
      S_DELAY,
      S_DONE
   } state_t;

   state_t              state_q;
   logic [SAMPLE_W-1:0] sample_buf_q;
   logic [IDX_W-1:0]    idx_q;
   logic [DLY_W-1:0]    dly_q;
   logic                tx_dv_q;
   logic [7:0]          tx_byte_q;
   logic                sample_ready_q;
   logic                busy_q;
   logic [FC_W-1:0]     frame_count_q;
   logic                burst_done_q;

   logic [SAMPLE_W-1:0] shifted;
   logic [7:0]          tx_byte_d;
   logic [FC_W-1:0]     frame_count_d;

   // Shifting the buffer left keeps byte k at the top, so channel 0 MSB goes first.
   always_comb begin
      shifted       = sample_buf_q << {idx_q, 3'b000};
      tx_byte_d     = (idx_q < IDX_PAY) ? shifted[SAMPLE_W-1 -: 8] : PAD_BYTE;
      frame_count_d = frame_count_q + FC_W'(1);
   end

   always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q        <= S_IDLE;
         sample_buf_q   <= '0;
         idx_q          <= '0;
         dly_q          <= '0;
         tx_dv_q        <= 1'b0;
         tx_byte_q      <= 8'h00;
         sample_ready_q <= 1'b0;
         busy_q         <= 1'b0;
         frame_count_q  <= '0;
         burst_done_q   <= 1'b0;
      end else begin
         tx_dv_q      <= 1'b0;
         burst_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  frame_count_q  <= '0;
                  sample_ready_q <= 1'b1;
                  busy_q         <= 1'b1;
                  state_q        <= S_WAIT_SAMPLE;
               end
            end
            S_WAIT_SAMPLE: begin
               if (sample_valid) begin
                  sample_buf_q   <= sample_data;
                  idx_q          <= '0;
                  sample_ready_q <= 1'b0;
                  state_q        <= S_SEND;
               end
            end
            S_SEND: begin
               if (tx_ready) begin
                  tx_dv_q   <= 1'b1;
                  tx_byte_q <= tx_byte_d;
                  state_q   <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (idx_q == IDX_LAST) begin
                  state_q <= S_DRAIN;
               end else begin
                  idx_q   <= idx_q + IDX_W'(1);
                  state_q <= S_SEND;
               end
            end
            S_DRAIN: begin
               if (tx_ready) begin
                  dly_q   <= '0;
                  state_q <= S_DELAY;
               end
            end
            S_DELAY: begin
               if (dly_q == DLY_LAST) begin
                  frame_count_q <= frame_count_d;
                  if (frame_count_d == FC_LAST) begin
                     burst_done_q <= 1'b1;
                     state_q      <= S_DONE;
                  end else begin
                     sample_ready_q <= 1'b1;
                     state_q        <= S_WAIT_SAMPLE;
                  end
               end else begin
                  dly_q <= dly_q + DLY_W'(1);
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign tx_dv        = tx_dv_q;
   assign tx_byte      = tx_byte_q;
   assign sample_ready = sample_ready_q;
   assign busy         = busy_q;
   assign frame_count  = frame_count_q;
   assign burst_done   = burst_done_q;
   assign tx_count     = TC_W'(FRAME_BYTES);

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Bench for spi_frame_sequencer with a small SPI master model that drops
// tx_ready one cycle after each strobe and holds it low for 32 cycles.
module tb_spi_frame_sequencer;

   localparam int NUM_CH           = 2;
   localparam int SAMPLE_BYTES     = 3;
   localparam int FRAME_BYTES      = 8;
   localparam int DELAY_CYCLES     = 10;
   localparam int FRAMES_PER_BURST = 3;
   localparam int MAX_BYTES_PER_CS = 32;
   localparam int SW               = 48;
   localparam int TC_W             = 6;
   localparam int FC_W             = 2;

   logic            CLK100MHZ    = 1'b0;
   logic            RESET_N      = 1'b0;
   logic            start        = 1'b0;
   logic [SW-1:0]   sample_data  = '0;
   logic            sample_valid = 1'b0;
   logic            sample_ready;
   logic [7:0]      tx_byte;
   logic            tx_dv;
   logic            tx_ready;
   logic [TC_W-1:0] tx_count;
   logic            busy;
   logic [FC_W-1:0] frame_count;
   logic            burst_done;

   always #5 CLK100MHZ = ~CLK100MHZ;

   spi_frame_sequencer #(
      .NUM_CH           (NUM_CH),
      .SAMPLE_BYTES     (SAMPLE_BYTES),
      .FRAME_BYTES      (FRAME_BYTES),
      .PAD_BYTE         (8'hAB),
      .DELAY_CYCLES     (DELAY_CYCLES),
      .FRAMES_PER_BURST (FRAMES_PER_BURST),
      .MAX_BYTES_PER_CS (MAX_BYTES_PER_CS)
   ) dut (
      .CLK100MHZ    (CLK100MHZ),
      .RESET_N      (RESET_N),
      .start        (start),
      .sample_data  (sample_data),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .tx_byte      (tx_byte),
      .tx_dv        (tx_dv),
      .tx_ready     (tx_ready),
      .tx_count     (tx_count),
      .busy         (busy),
      .frame_count  (frame_count),
      .burst_done   (burst_done)
   );

   int master_cnt = 0;
   always @(posedge CLK100MHZ or negedge RESET_N) begin
      if (!RESET_N) begin
         tx_ready   <= 1'b1;
         master_cnt <= 0;
      end else if (tx_dv) begin
         tx_ready   <= 1'b0;
         master_cnt <= 32;
      end else if (master_cnt == 1) begin
         tx_ready   <= 1'b1;
         master_cnt <= 0;
      end else if (master_cnt != 0) begin
         master_cnt <= master_cnt - 1;
      end
   end

   logic [63:0] rx_shift   = '0;
   int          rx_cnt     = 0;
   int          done_cnt   = 0;
   int          consec_err = 0;
   logic        prev_dv    = 1'b0;
   logic        prev_done  = 1'b0;
   always @(posedge CLK100MHZ) begin
      prev_dv   <= tx_dv;
      prev_done <= burst_done;
      if (tx_dv) begin
         rx_shift <= {rx_shift[55:0], tx_byte};
         rx_cnt   <= rx_cnt + 1;
      end
      if (burst_done) done_cnt <= done_cnt + 1;
      consec_err <= consec_err + int'(tx_dv && prev_dv) + int'(burst_done && prev_done);
   end

   typedef struct {
      logic [47:0] sample;
      logic [63:0] exp_bytes;
   } vec_t;
   vec_t vecs [5];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic do_start();
      @(negedge CLK100MHZ);
      start = 1'b1;
      @(negedge CLK100MHZ);
      start = 1'b0;
   endtask

   // Caller sits at a negedge with sample_ready high; returns at the negedge after the handshake.
   task automatic handshake(input logic [47:0] s);
      sample_data  = s;
      sample_valid = 1'b1;
      @(negedge CLK100MHZ);
      sample_valid = 1'b0;
      sample_data  = ~s;
   endtask

   task automatic run_frame(input int i, input int exp_fc, input bit pulse_start, input bit last);
      int base;
      int n;
      base = rx_cnt;
      handshake(vecs[i].sample);
      chk("dv_low_after_handshake", 64'(tx_dv), 64'd0);
      chk("ready_low_in_frame", 64'(sample_ready), 64'd0);
      @(negedge CLK100MHZ);
      chk("dv_latency", 64'(tx_dv), 64'd1);
      if (pulse_start) begin
         start = 1'b1;
         @(negedge CLK100MHZ);
         start = 1'b0;
         chk("busy_after_stray_start", 64'(busy), 64'd1);
      end
      n = 0;
      while ((rx_cnt - base) < 8 && n < 2000) begin
         @(negedge CLK100MHZ);
         n++;
      end
      chk("frame_bytes", rx_shift, vecs[i].exp_bytes);
      if (!last) begin
         n = 0;
         while (!tx_ready && n < 100) begin
            @(negedge CLK100MHZ);
            n++;
         end
         n = 0;
         do begin
            @(posedge CLK100MHZ);
            n++;
            @(negedge CLK100MHZ);
         end while (!sample_ready && n < 100);
         chk("gap_cycles", 64'(n), 64'd11);
         chk("frame_count", 64'(frame_count), 64'(exp_fc));
      end else begin
         n = 0;
         while (!burst_done && n < 200) begin
            @(negedge CLK100MHZ);
            n++;
         end
         chk("burst_done_high", 64'(burst_done), 64'd1);
         chk("final_frame_count", 64'(frame_count), 64'(exp_fc));
         chk("busy_in_done", 64'(busy), 64'd1);
         start = 1'b1;
         @(negedge CLK100MHZ);
         start = 1'b0;
         chk("burst_done_one_cycle", 64'(burst_done), 64'd0);
         chk("idle_after_burst", 64'(busy), 64'd0);
         chk("ready_low_after_burst", 64'(sample_ready), 64'd0);
         chk("frame_count_held", 64'(frame_count), 64'(exp_fc));
         repeat (3) @(negedge CLK100MHZ);
         chk("start_at_done_ignored", 64'(busy), 64'd0);
      end
      chk("pulses_per_frame", 64'(rx_cnt - base), 64'd8);
   endtask

   initial begin
      #400_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int n;
      vecs[0] = '{48'hF1020304056F, 64'hF1020304056FABAB};
      vecs[1] = '{48'h112233445566, 64'h112233445566ABAB};
      vecs[2] = '{48'hA5A50000FFFF, 64'hA5A50000FFFFABAB};
      vecs[3] = '{48'h0123456789AB, 64'h0123456789ABABAB};
      vecs[4] = '{48'hDEADBEEFCAFE, 64'hDEADBEEFCAFEABAB};

      repeat (3) @(negedge CLK100MHZ);
      chk("rst_tx_dv", 64'(tx_dv), 64'd0);
      chk("rst_sample_ready", 64'(sample_ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_burst_done", 64'(burst_done), 64'd0);
      chk("rst_tx_byte", 64'(tx_byte), 64'd0);
      chk("rst_frame_count", 64'(frame_count), 64'd0);
      chk("tx_count", 64'(tx_count), 64'd8);
      RESET_N = 1'b1;
      repeat (5) @(negedge CLK100MHZ);
      chk("idle_no_ready", 64'(sample_ready), 64'd0);
      chk("idle_not_busy", 64'(busy), 64'd0);

      do_start();
      chk("start_to_ready", 64'(sample_ready), 64'd1);
      chk("start_to_busy", 64'(busy), 64'd1);
      base = rx_cnt;
      repeat (50) @(negedge CLK100MHZ);
      chk("no_dv_without_valid", 64'(rx_cnt - base), 64'd0);
      chk("ready_held_waiting", 64'(sample_ready), 64'd1);

      run_frame(0, 1, 1'b0, 1'b0);
      run_frame(1, 2, 1'b1, 1'b0);
      run_frame(2, 3, 1'b0, 1'b1);
      chk("one_burst_done", 64'(done_cnt), 64'd1);

      do_start();
      run_frame(3, 1, 1'b0, 1'b0);
      base = rx_cnt;
      handshake(vecs[4].sample);
      n = 0;
      while (!(tx_dv && (rx_cnt - base) == 3) && n < 2000) begin
         @(negedge CLK100MHZ);
         n++;
      end
      chk("reached_byte4_count", 64'(rx_cnt - base), 64'd3);
      chk("reached_byte4_dv", 64'(tx_dv), 64'd1);
      RESET_N = 1'b0;
      #1;
      chk("midrst_tx_dv", 64'(tx_dv), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_frame_count", 64'(frame_count), 64'd0);
      chk("midrst_sample_ready", 64'(sample_ready), 64'd0);
      repeat (3) @(negedge CLK100MHZ);
      RESET_N = 1'b1;
      @(negedge CLK100MHZ);
      do_start();
      run_frame(4, 1, 1'b0, 1'b0);

      chk("no_back_to_back_pulses", 64'(consec_err), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
